if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
Fetch-stage sequencer for the combinational instruction memory (IM, word-indexed, base 0x0000_3000, 4096 words).
- Owns the PC and drives the IM address.
- Arbitrates next-PC sources: exception, ERET, stall, branch/jump redirect, sequential.
- Registers the fetched word into the IF/ID pipeline register and flags address errors.
- Sits between the hazard/CP0 logic and the D stage of the pipelined MIPS core.

Parameters:
- BASE_ADDR, 32'h0000_3000: reset PC; lowest legal fetch address.
- DEPTH_WORDS, 4096: IM size in words. Legal range is [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
- EXC_VECTOR, 32'h0000_4180: exception entry PC.
- NOP_WORD, 32'h0000_0000: instruction injected for bubbles and faulting fetches.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit freeze of PC and IF/ID
- flush  in  1  squash the IF/ID contents next edge
- redirect_valid  in  1  branch/jump taken, from the D stage
- redirect_pc  in  32  branch/jump target
- exc_valid  in  1  take exception, from CP0
- eret_valid  in  1  return from exception
- epc  in  32  ERET target
- im_addr  out  32  IM address (equals the PC)
- im_instr  in  32  IM read data, same cycle
- id_instr  out  32  IF/ID instruction
- id_pc  out  32  IF/ID PC
- id_valid  out  1  IF/ID holds a real fetch
- id_adel  out  1  fetch address error (AdEL) for the IF/ID entry
- fetch_count  out  32  count of valid fetches committed into IF/ID

Behaviour:
- **States:**
  - BOOT: entered on reset; lasts exactly one cycle after reset deasserts.
  - RUN: normal operation.
  - BOOT to RUN is unconditional. In BOOT, the PC holds BASE_ADDR, IF/ID is not loaded (stays a bubble), and all inputs except reset are ignored.
- **Reset (synchronous, wins over everything):**
  - pc = BASE_ADDR, state = BOOT.
  - id_instr = NOP_WORD, id_pc = BASE_ADDR, id_valid = 0, id_adel = 0, fetch_count = 0.
- **Address path:** im_addr = pc, combinational. IM read is combinational, so fetch latency is 1 cycle: a PC value appears in id_* on the edge after it is presented.
- **Fault detection:** fault = (pc[1:0] != 0) OR (pc < BASE_ADDR) OR (pc >= BASE_ADDR + 4*DEPTH_WORDS). All comparisons are unsigned, 32-bit.
- **Next-PC priority in RUN (highest first):**
  1. exc_valid → EXC_VECTOR
  2. eret_valid → epc
  3. stall → pc (hold)
  4. redirect_valid → redirect_pc
  5. otherwise pc + 4, with 32-bit wrap (0xFFFF_FFFC + 4 = 0)
- Exception and ERET override stall. A redirect asserted during a stall is dropped; the D stage re-asserts it because it is also stalled.
- **IF/ID update in RUN (priority):**
  - exc_valid, eret_valid or flush: load bubble (NOP_WORD, valid 0, adel 0, id_pc = pc).
  - else stall: hold all id_* fields.
  - else load id_instr = (fault ? NOP_WORD : im_instr), id_pc = pc, id_valid = 1, id_adel = fault.
- **Delay slot:** redirect does not squash IF/ID, so the delay-slot instruction proceeds. flush alone does not alter the PC.
- **fetch_count:** increments by 1 on every edge that loads id_valid = 1, including faulting fetches. Wraps at 2^32.
- **Simultaneous events:**
  - exc_valid with eret_valid → exception wins.
  - flush with stall → flush wins for IF/ID; the PC still holds.
- **Reset mid-operation:** reset asserted in any state forces the reset values above on the next edge and re-enters BOOT.

Decomposition:
- Shared package (cpu_defs): BASE_ADDR, EXC_VECTOR and NOP_WORD constants; state encoding BOOT = 1'b0, RUN = 1'b1.
- One natural sub-module, fetch_pc_sel: combinational next-PC mux plus fault check. The IF/ID register and counter stay in the top.

Test Plan:
1. Reset held 2 cycles, then released.
   - BOOT cycle: im_addr = 0x3000, id_valid = 0.
   - Next edge: id_pc = 0x3000, id_instr = IM[0], fetch_count = 1.
   - Then im_addr = 0x3004.
2. Sequential fetch for 4 cycles, then stall for 2 cycles.
   - During stall: im_addr holds 0x3010 and id_* hold the 0x300C entry.
   - After release, fetch resumes at 0x3010; fetch_count stops during stall.
3. redirect_valid with redirect_pc = 0x3040 while pc = 0x3008.
   - id_pc = 0x3008 (delay slot kept, valid 1).
   - Next im_addr = 0x3040.
4. exc_valid together with stall and redirect (0x3100).
   - pc → 0x4180 and IF/ID becomes a bubble.
   - Then eret_valid with epc = 0x3020 → pc = 0x3020.
5. redirect_pc = 0x3002, then redirect_pc = 0x7000.
   - Each fetch yields id_adel = 1, id_instr = 0x0000_0000, id_valid = 1.
6. Reset asserted mid-RUN at pc = 0x3080 with stall = 1.
   - Next edge: pc = 0x3000, id_valid = 0, fetch_count = 0, state BOOT.

Source files
------------

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared fetch-stage constants and state encoding
package cpu_defs;

    localparam logic [31:0] BASE_ADDR   = 32'h0000_3000;
    localparam int unsigned DEPTH_WORDS = 4096;
    localparam logic [31:0] EXC_VECTOR  = 32'h0000_4180;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// rtl/fetch_pc_sel.sv - next-PC mux and fetch address fault check
// Ports:
//   pc, exc_valid, eret_valid, epc, stall, redirect_valid, redirect_pc : next-PC sources
//   next_pc : selected PC for the next edge
//   fault   : current pc is misaligned or outside the instruction memory
module fetch_pc_sel
    import cpu_defs::*;
#(
    parameter logic [31:0] BASE_ADDR   = cpu_defs::BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = cpu_defs::DEPTH_WORDS,
    parameter logic [31:0] EXC_VECTOR  = cpu_defs::EXC_VECTOR
) (
    input  logic [31:0] pc,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] next_pc,
    output logic        fault
);

    // Upper bound is kept at 33 bits so a memory ending exactly at 2^32 still compares correctly.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    assign fault = (pc[1:0] != 2'b00) || (pc < BASE_ADDR) || ({1'b0, pc} >= LIMIT);

    // Exception and ERET override stall; a redirect seen during stall is dropped
    // because the stalled D stage presents it again.
    always_comb begin
        next_pc = pc + 32'd4;
        if (exc_valid) begin
            next_pc = EXC_VECTOR;
        end else if (eret_valid) begin
            next_pc = epc;
        end else if (stall) begin
            next_pc = pc;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch-stage sequencer: PC, IM address, IF/ID register
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   stall, flush              : hazard freeze of PC and IF/ID, squash of IF/ID
//   redirect_valid/pc         : taken branch/jump from D
//   exc_valid, eret_valid/epc : CP0 exception entry and return
//   im_addr, im_instr         : combinational instruction memory port
//   id_instr/pc/valid/adel    : IF/ID register contents
//   fetch_count               : valid fetches committed into IF/ID
module if_fetch_ctrl
    import cpu_defs::*;
#(
    parameter logic [31:0] BASE_ADDR   = cpu_defs::BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = cpu_defs::DEPTH_WORDS,
    parameter logic [31:0] EXC_VECTOR  = cpu_defs::EXC_VECTOR,
    parameter logic [31:0] NOP_WORD    = cpu_defs::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        id_adel,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic         id_valid_q, id_valid_d;
    logic         id_adel_q, id_adel_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [31:0]  next_pc;
    logic         fault;

    fetch_pc_sel #(
        .BASE_ADDR   (BASE_ADDR),
        .DEPTH_WORDS (DEPTH_WORDS),
        .EXC_VECTOR  (EXC_VECTOR)
    ) u_pc_sel (
        .pc             (pc_q),
        .exc_valid      (exc_valid),
        .eret_valid     (eret_valid),
        .epc            (epc),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (next_pc),
        .fault          (fault)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= BASE_ADDR;
            id_instr_q <= NOP_WORD;
            id_pc_q    <= BASE_ADDR;
            id_valid_q <= 1'b0;
            id_adel_q  <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
            id_adel_q  <= id_adel_d;
            cnt_q      <= cnt_d;
        end
    end

    // BOOT spends one cycle presenting BASE_ADDR with IF/ID left as a bubble.
    always_comb begin
        state_d    = RUN;
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        id_adel_d  = id_adel_q;
        cnt_d      = cnt_q;
        if (state_q == RUN) begin
            pc_d = next_pc;
            if (exc_valid || eret_valid || flush) begin
                id_instr_d = NOP_WORD;
                id_pc_d    = pc_q;
                id_valid_d = 1'b0;
                id_adel_d  = 1'b0;
            end else if (!stall) begin
                // Faulting fetches still count: they carry the AdEL down the pipe.
                id_instr_d = fault ? NOP_WORD : im_instr;
                id_pc_d    = pc_q;
                id_valid_d = 1'b1;
                id_adel_d  = fault;
                cnt_d      = cnt_q + 32'd1;
            end
        end
    end

    assign im_addr     = pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_valid    = id_valid_q;
    assign id_adel     = id_adel_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - scoreboard bench for if_fetch_ctrl against a reference model
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        exc_valid = 1'b0;
    logic        eret_valid = 1'b0;
    logic [31:0] epc = 32'd0;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        id_adel;
    logic [31:0] fetch_count;

    if_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_valid      (exc_valid),
        .eret_valid     (eret_valid),
        .epc            (epc),
        .im_addr        (im_addr),
        .im_instr       (im_instr),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_valid       (id_valid),
        .id_adel        (id_adel),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [4096];

    function automatic logic [31:0] im_lookup(input logic [31:0] a);
        if (a >= 32'h3000 && a < 32'h7000)
            return mem[(a - 32'h3000) >> 2];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    assign im_instr = im_lookup(im_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] idpc;
        logic [31:0] cnt;
        logic        valid;
        logic        adel;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural state after each edge.
    bit          m_boot = 1'b1;
    logic [31:0] m_pc = 32'h3000;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_idpc = 32'h3000;
    logic [31:0] m_cnt = 32'd0;
    bit          m_valid = 1'b0;
    bit          m_adel = 1'b0;

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h want %h", tag, name, act, exp);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit fl, input bit rv,
                        input logic [31:0] rpc, input bit ex, input bit er,
                        input logic [31:0] ep, input string tag);
        bit          f;
        logic [31:0] old;
        exp_t        e;
        @(negedge clk);
        reset = rst; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
        exc_valid = ex; eret_valid = er; epc = ep;
        if (rst) begin
            m_boot = 1'b1; m_pc = 32'h3000; m_instr = 32'd0; m_idpc = 32'h3000;
            m_valid = 1'b0; m_adel = 1'b0; m_cnt = 32'd0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            old = m_pc;
            f = (old % 4 != 0) || (old < 32'h3000) || (old >= 32'h7000);
            if (ex)      m_pc = 32'h4180;
            else if (er) m_pc = ep;
            else if (st) m_pc = old;
            else if (rv) m_pc = rpc;
            else         m_pc = old + 32'd4;
            if (ex || er || fl) begin
                m_instr = 32'd0; m_idpc = old; m_valid = 1'b0; m_adel = 1'b0;
            end else if (!st) begin
                m_instr = f ? 32'd0 : im_lookup(old);
                m_idpc = old; m_valid = 1'b1; m_adel = f; m_cnt = m_cnt + 32'd1;
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.idpc = m_idpc; e.cnt = m_cnt;
        e.valid = m_valid; e.adel = m_adel; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 32'd0, 0, 0, 32'd0, tag);
    endtask

    task automatic redir(input logic [31:0] t, input string tag);
        step(0, 0, 0, 1, t, 0, 0, 32'd0, tag);
    endtask

    // Monitor: compares every output just after each edge that has an expectation queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, "im_addr", im_addr, e.pc);
                chk(e.tag, "id_instr", id_instr, e.instr);
                chk(e.tag, "id_pc", id_pc, e.idpc);
                chk(e.tag, "id_valid", {31'd0, id_valid}, {31'd0, e.valid});
                chk(e.tag, "id_adel", {31'd0, id_adel}, {31'd0, e.adel});
                chk(e.tag, "fetch_count", fetch_count, e.cnt);
            end
        end
    end

    initial begin
        logic [31:0] rpc, ep;
        bit rst, st, fl, rv, ex, er;
        int k;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;

        // Reset, boot, sequential fetch, stall
        step(1, 0, 0, 0, 32'd0, 0, 0, 32'd0, "reset0");
        step(1, 0, 0, 0, 32'd0, 0, 0, 32'd0, "reset1");
        idle("boot");
        idle("first_fetch");
        for (int i = 0; i < 3; i++) idle("seq");
        step(0, 1, 0, 0, 32'd0, 0, 0, 32'd0, "stall0");
        step(0, 1, 0, 1, 32'h3200, 0, 0, 32'd0, "stall_redir_drop");
        idle("resume");
        idle("resume2");

        // Redirect with delay slot from 0x3008
        step(1, 0, 0, 0, 32'd0, 0, 0, 32'd0, "reset2");
        idle("boot2");
        idle("f3000");
        idle("f3004");
        redir(32'h3040, "redir3040");
        idle("f3040");

        // Exception over stall+redirect, then ERET
        step(0, 1, 0, 1, 32'h3100, 1, 0, 32'd0, "exc");
        idle("f4180");
        step(0, 0, 0, 0, 32'd0, 0, 1, 32'h3020, "eret");
        step(0, 0, 0, 0, 32'd0, 1, 1, 32'h3020, "exc_eret");
        step(0, 1, 1, 0, 32'd0, 0, 0, 32'd0, "flush_stall");
        step(0, 0, 1, 0, 32'd0, 0, 0, 32'd0, "flush");

        // Address errors and range boundaries
        redir(32'h3002, "redir3002");
        idle("f3002");
        redir(32'h7000, "redir7000");
        idle("f7000");
        redir(32'h6FFC, "redir6ffc");
        idle("f6ffc");
        idle("f7000b");
        redir(32'h2FFC, "redir2ffc");
        idle("f2ffc");
        redir(32'hFFFF_FFFC, "redir_top");
        idle("wrap");
        idle("f0");

        // Reset mid-run while stalled
        redir(32'h3080, "redir3080");
        step(1, 1, 0, 0, 32'd0, 0, 0, 32'd0, "reset_mid");
        idle("boot3");
        idle("f3000b");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            ex  = ($urandom_range(0, 99) < 4);
            er  = ($urandom_range(0, 99) < 4);
            st  = ($urandom_range(0, 99) < 20);
            fl  = ($urandom_range(0, 99) < 10);
            rv  = ($urandom_range(0, 99) < 15);
            k = $urandom_range(0, 9);
            if (k <= 6)      rpc = 32'h3000 + 4 * $urandom_range(0, 4095);
            else if (k == 7) rpc = 32'h3000 + $urandom_range(0, 16383);
            else if (k == 8) rpc = 32'h2FF0 + 4 * $urandom_range(0, 3) + 32'h4000 * $urandom_range(0, 1);
            else             rpc = 32'hFFFF_FFF8 + 4 * $urandom_range(0, 1);
            ep = 32'h3000 + 4 * $urandom_range(0, 4095);
            step(rst, st, fl, rv, rpc, ex, er, ep, "rand");
        end

        repeat (3) @(posedge clk);
        #2;
        chk("end", "sb_drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
